// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the issue stage and the ALU.
//   ALU opcodes (ADD..SRA), MIPS R-type funct codes, issue FSM state
//   encoding and the funct -> ALU opcode decoder.
package alu_pkg;

   localparam logic [2:0] ADD = 3'b000;
   localparam logic [2:0] SUB = 3'b001;
   localparam logic [2:0] AND = 3'b010;
   localparam logic [2:0] OR  = 3'b011;
   localparam logic [2:0] SRL = 3'b100;
   localparam logic [2:0] SRA = 3'b101;

   localparam logic [5:0] FUNCT_ADDU = 6'h21;
   localparam logic [5:0] FUNCT_SUBU = 6'h23;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_SRLV = 6'h06;
   localparam logic [5:0] FUNCT_SRAV = 6'h07;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   typedef struct packed {
      logic       legal;
      logic       shift;   // operand swap: A=GPR[rt], B=GPR[rs][4:0]
      logic [2:0] op;
   } dec_t;

   // Illegal words decode to op=ADD (000) with legal=0.
   function automatic dec_t decode(input logic [31:0] w);
      dec_t d;
      d = '0;
      if (w[31:26] == 6'd0) begin
         unique case (w[5:0])
            FUNCT_ADDU: begin d.legal = 1'b1; d.op = ADD; end
            FUNCT_SUBU: begin d.legal = 1'b1; d.op = SUB; end
            FUNCT_AND:  begin d.legal = 1'b1; d.op = AND; end
            FUNCT_OR:   begin d.legal = 1'b1; d.op = OR;  end
            FUNCT_SRLV: begin d.legal = 1'b1; d.shift = 1'b1; d.op = SRL; end
            FUNCT_SRAV: begin d.legal = 1'b1; d.shift = 1'b1; d.op = SRA; end
            default: ;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction handshake plus ALU operand/result bus.
//   master: upstream/ALU side (drives instr_valid, instr, alu_c)
//   slave : issue stage side (drives instr_ready, alu_a, alu_b, alu_op)
interface alu_issue_if;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_op;
   logic [31:0] alu_c;

   modport master (output instr_valid, instr, alu_c,
                   input  instr_ready, alu_a, alu_b, alu_op);
   modport slave  (input  instr_valid, instr, alu_c,
                   output instr_ready, alu_a, alu_b, alu_op);
endinterface

// File: rtl/alu_issue_grf.sv
// grf: 32x32 general register file.
//   ra1/ra2/ra3 -> rd1/rd2/rd3 : combinational reads ($0 reads zero)
//   ld_*  : preload write request (caller qualifies with IDLE)
//   wb_*  : write-back request
//   reset : asynchronous active-low clear of every register
module grf (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  ra3,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   output logic [31:0] rd3,
   input  logic        ld_en,
   input  logic [4:0]  ld_addr,
   input  logic [31:0] ld_data,
   input  logic        wb_en,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data
);

   logic [31:0] regs [32];
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;

   // Preload is only possible in IDLE and write-back only in WB, so the
   // two requests never collide; WB is given priority for definiteness.
   always_comb begin
      we = ld_en | wb_en;
      wa = wb_en ? wb_addr : ld_addr;
      wd = wb_en ? wb_data : ld_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && (wa != 5'd0)) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
   assign rd3 = (ra3 == 5'd0) ? '0 : regs[ra3];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: serialized issue/write-back stage in front of the ALU.
//   clk, reset (async, active-low)
//   bus      : instr handshake in, ALU operands out, ALU result in
//   ld_*     : host preload of a GPR, honoured in IDLE only
//   wb_*     : write-back strobe/address/data, valid in WB
//   err      : one-cycle pulse in EXEC for an unsupported instruction
//   dbg_addr/dbg_data : combinational GPR read
// One instruction every 3 cycles: IDLE (accept) -> EXEC -> WB.
module alu_issue
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   alu_issue_if.slave  bus,
   input  logic        ld_en,
   input  logic [4:0]  ld_addr,
   input  logic [31:0] ld_data,
   output logic        wb_en,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic        err,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   state_t      state, state_nx;
   logic [31:0] ir;
   logic [31:0] res;
   dec_t        dec;
   logic [31:0] rs_data, rt_data;
   logic        accept;

   assign dec    = decode(ir);
   assign accept = bus.instr_valid && (state == S_IDLE);

   grf u_grf (
      .clk     (clk),
      .reset   (reset),
      .ra1     (ir[25:21]),
      .ra2     (ir[20:16]),
      .ra3     (dbg_addr),
      .rd1     (rs_data),
      .rd2     (rt_data),
      .rd3     (dbg_data),
      .ld_en   (ld_en && (state == S_IDLE)),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (bus.instr_valid) state_nx = S_EXEC;
         S_EXEC:  state_nx = dec.legal ? S_WB : S_IDLE;
         S_WB:    state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      bus.instr_ready = (state == S_IDLE);
      err             = (state == S_EXEC) && !dec.legal;
      wb_en           = (state == S_WB);
      wb_addr         = wb_en ? ir[15:11] : '0;
      wb_data         = wb_en ? res : '0;
   end

   // Operand routing is driven from ir in every state; it only matters in EXEC.
   always_comb begin
      bus.alu_op = dec.op;
      if (dec.shift) begin
         bus.alu_a = rt_data;
         bus.alu_b = {27'd0, rs_data[4:0]};
      end else begin
         bus.alu_a = rs_data;
         bus.alu_b = rt_data;
      end
   end

   // Instruction and result registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ir  <= '0;
         res <= '0;
      end else begin
         if (accept) ir <= bus.instr;
         if ((state == S_EXEC) && dec.legal) res <= bus.alu_c;
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed-vector bench for alu_issue with a stand-in ALU.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        reset;
   logic        ld_en;
   logic [4:0]  ld_addr;
   logic [31:0] ld_data;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        err;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   int checks = 0;
   int errors = 0;

   alu_issue_if bus ();

   alu_issue dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .ld_en    (ld_en),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .err      (err),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always #5 clk = ~clk;

   // Stand-in combinational ALU
   always_comb begin
      case (bus.alu_op)
         3'b000:  bus.alu_c = bus.alu_a + bus.alu_b;
         3'b001:  bus.alu_c = bus.alu_a - bus.alu_b;
         3'b010:  bus.alu_c = bus.alu_a & bus.alu_b;
         3'b011:  bus.alu_c = bus.alu_a | bus.alu_b;
         3'b100:  bus.alu_c = bus.alu_a >> bus.alu_b[4:0];
         3'b101:  bus.alu_c = $unsigned($signed(bus.alu_a) >>> bus.alu_b[4:0]);
         default: bus.alu_c = '0;
      endcase
   end

   // Accept monitor: cycle number of each handshake
   int unsigned cyc = 0;
   int unsigned acc_n = 0;
   int unsigned acc_cyc [64];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.instr_valid && bus.instr_ready) begin
         if (acc_n < 64) acc_cyc[acc_n] <= cyc;
         acc_n <= acc_n + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] f);
      return {6'd0, rs, rt, rd, 5'd0, f};
   endfunction

   task automatic dbg_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
      dbg_addr = a;
      #1;
      check(tag, dbg_data, exp);
   endtask

   task automatic preload(input logic [4:0] a, input logic [31:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   // Issue from IDLE; optionally hold a preload request through EXEC and WB.
   task automatic run_op(input string tag, input logic [31:0] w, input logic [4:0] rd,
                         input logic [31:0] expd, input bit ld_during);
      check({tag, "/rdy_idle"}, bus.instr_ready, 1'b1);
      bus.instr = w; bus.instr_valid = 1'b1;
      @(negedge clk);                          // EXEC
      bus.instr_valid = 1'b0;
      ld_en = 1'b0;
      if (ld_during) begin
         ld_en = 1'b1; ld_addr = 5'd16; ld_data = 32'hDEAD_BEEF;
      end
      check({tag, "/exec_err"}, err, 1'b0);
      check({tag, "/exec_rdy"}, bus.instr_ready, 1'b0);
      check({tag, "/exec_wb"}, wb_en, 1'b0);
      @(negedge clk);                          // WB
      check({tag, "/wb_en"}, wb_en, 1'b1);
      check({tag, "/wb_addr"}, wb_addr, rd);
      check({tag, "/wb_data"}, wb_data, expd);
      @(negedge clk);                          // IDLE
      ld_en = 1'b0;
      check({tag, "/idle_wb"}, wb_en, 1'b0);
      check({tag, "/idle_rdy"}, bus.instr_ready, 1'b1);
      dbg_check({tag, "/dbg"}, rd, (rd == 5'd0) ? 32'd0 : expd);
   endtask

   task automatic run_illegal(input string tag, input logic [31:0] w, input logic [4:0] rd);
      bus.instr = w; bus.instr_valid = 1'b1;
      @(negedge clk);                          // EXEC
      bus.instr_valid = 1'b0;
      check({tag, "/err"}, err, 1'b1);
      check({tag, "/alu_op"}, bus.alu_op, 3'b000);
      check({tag, "/wb"}, wb_en, 1'b0);
      @(negedge clk);                          // back in IDLE
      check({tag, "/err_off"}, err, 1'b0);
      check({tag, "/wb_off"}, wb_en, 1'b0);
      check({tag, "/rdy"}, bus.instr_ready, 1'b1);
      dbg_check({tag, "/gpr"}, rd, 32'd0);
   endtask

   logic [31:0] bw [3];
   logic [4:0]  brd [3];
   logic [31:0] bexp [3];
   int unsigned base;

   initial begin
      reset = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
      bus.instr_valid = 1'b0; bus.instr = '0;

      // Reset state
      @(negedge clk); @(negedge clk);
      check("rst/rdy", bus.instr_ready, 1'b1);
      check("rst/alu_a", bus.alu_a, 32'd0);
      check("rst/alu_b", bus.alu_b, 32'd0);
      check("rst/alu_op", bus.alu_op, 3'b000);
      check("rst/wb_en", wb_en, 1'b0);
      check("rst/wb_addr", wb_addr, 5'd0);
      check("rst/wb_data", wb_data, 32'd0);
      check("rst/err", err, 1'b0);
      check("rst/dbg", dbg_data, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Arithmetic and logic
      preload(5'd1, 32'd5);
      preload(5'd2, 32'd3);
      dbg_check("ld/r1", 5'd1, 32'd5);
      run_op("addu", rtype(5'd1, 5'd2, 5'd3, 6'h21), 5'd3, 32'd8, 1'b0);
      run_op("subu", rtype(5'd2, 5'd1, 5'd4, 6'h23), 5'd4, 32'hFFFF_FFFE, 1'b0);
      preload(5'd8, 32'hF0F0_F0F0);
      preload(5'd9, 32'h0FF0_0FF0);
      run_op("and", rtype(5'd8, 5'd9, 5'd10, 6'h24), 5'd10, 32'h00F0_00F0, 1'b0);
      run_op("or",  rtype(5'd8, 5'd9, 5'd11, 6'h25), 5'd11, 32'hFFF0_FFF0, 1'b0);

      // Shifts: srav $7,$5,$6 -> rt=$5 shifted by $6[4:0]
      preload(5'd5, 32'h8000_0000);
      preload(5'd6, 32'h0000_0024);
      bus.instr = rtype(5'd6, 5'd5, 5'd7, 6'h07); bus.instr_valid = 1'b1;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      check("srav/alu_a", bus.alu_a, 32'h8000_0000);
      check("srav/alu_b", bus.alu_b, 32'd4);
      check("srav/alu_op", bus.alu_op, 3'b101);
      @(negedge clk);
      check("srav/wb_data", wb_data, 32'hF800_0000);
      check("srav/wb_addr", wb_addr, 5'd7);
      @(negedge clk);
      dbg_check("srav/dbg", 5'd7, 32'hF800_0000);
      run_op("srlv", rtype(5'd6, 5'd5, 5'd12, 6'h06), 5'd12, 32'h0800_0000, 1'b0);

      // Illegal instructions
      run_illegal("ill_op", {6'h08, 5'd1, 5'd2, 5'd13, 5'd0, 6'h21}, 5'd13);
      run_illegal("ill_fn", rtype(5'd1, 5'd2, 5'd14, 6'h20), 5'd14);

      // Write to $0 is discarded but still pulses wb_en
      run_op("r0", rtype(5'd1, 5'd2, 5'd0, 6'h21), 5'd0, 32'd8, 1'b0);

      // Preload during EXEC/WB is ignored
      run_op("ldexec", rtype(5'd1, 5'd2, 5'd15, 6'h21), 5'd15, 32'd8, 1'b1);
      dbg_check("ldexec/r16", 5'd16, 32'd0);

      // Preload and accept on the same edge: instruction sees new $1
      ld_en = 1'b1; ld_addr = 5'd1; ld_data = 32'd100;
      run_op("ldacc", rtype(5'd1, 5'd2, 5'd17, 6'h21), 5'd17, 32'd103, 1'b0);
      dbg_check("ldacc/r1", 5'd1, 32'd100);

      // instr_valid held high: accepts exactly 3 cycles apart
      bw[0] = rtype(5'd1, 5'd2, 5'd18, 6'h21); brd[0] = 5'd18; bexp[0] = 32'd103;
      bw[1] = rtype(5'd1, 5'd2, 5'd19, 6'h23); brd[1] = 5'd19; bexp[1] = 32'd97;
      bw[2] = rtype(5'd1, 5'd8, 5'd20, 6'h25); brd[2] = 5'd20; bexp[2] = 32'hF0F0_F0F4;
      base = acc_n;
      bus.instr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         int unsigned n;
         n = 0;
         bus.instr = bw[i];
         while ((acc_n <= base + i) && (n < 20)) begin
            @(negedge clk);
            n++;
         end
      end
      bus.instr_valid = 1'b0;
      check("b2b/count", acc_n - base, 32'd3);
      @(negedge clk); @(negedge clk); @(negedge clk);
      check("b2b/still3", acc_n - base, 32'd3);
      check("b2b/gap01", acc_cyc[base + 1] - acc_cyc[base], 32'd3);
      check("b2b/gap12", acc_cyc[base + 2] - acc_cyc[base + 1], 32'd3);
      for (int i = 0; i < 3; i++) dbg_check($sformatf("b2b/r%0d", brd[i]), brd[i], bexp[i]);

      // Reset asserted during EXEC aborts the instruction
      bus.instr = rtype(5'd1, 5'd2, 5'd21, 6'h21); bus.instr_valid = 1'b1;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      reset = 1'b0;
      #1;
      check("rstx/rdy", bus.instr_ready, 1'b1);
      check("rstx/wb", wb_en, 1'b0);
      check("rstx/alu_a", bus.alu_a, 32'd0);
      dbg_check("rstx/r1", 5'd1, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      check("rstx/wb2", wb_en, 1'b0);
      @(negedge clk);
      check("rstx/wb3", wb_en, 1'b0);
      dbg_check("rstx/r21", 5'd21, 32'd0);
      dbg_check("rstx/r3", 5'd3, 32'd0);
      dbg_check("rstx/r20", 5'd20, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
